// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hold, branch flush and a stall watchdog.
// Holds the fetched PC/instruction pair and exposes the decoded rs1/rs2/rd fields
// so the hazard unit can compare them in the following cycle.
// Optional feature macro: IF_ID_STALL_STATS_EN builds the total stall/flush counters;
// without it stall_cnt_o and flush_cnt_o read as zero.

module if_id_stage #(
    parameter int              XLEN       = 32,
    parameter int              REG_ADDR_W = 5,
    parameter logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h00000013),
    parameter int              HOLD_MAX   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [XLEN-1:0]       instr_i,
    input  logic                  valid_i,
    input  logic                  IF_ID_write_i,
    input  logic                  flush_i,
    output logic [XLEN-1:0]       pc_o,
    output logic [XLEN-1:0]       instr_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] rs1_addr_o,
    output logic [REG_ADDR_W-1:0] rs2_addr_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  holding_o,
    output logic                  watchdog_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HOLD    = 2'd1,
        FLUSHED = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    state_t     state_q;
    state_t     state_d;
    logic       take_flush;
    logic       take_hold;
    logic [7:0] hold_cnt_q;

    // Resolve this edge's action (flush beats hold beats load) and the next state.
    always_comb begin
        take_flush = 1'b0;
        take_hold  = 1'b0;
        state_d    = RUN;
        if (flush_i) begin
            take_flush = 1'b1;
            state_d    = FLUSHED;
        end else if (!IF_ID_write_i) begin
            take_hold = 1'b1;
            state_d   = HOLD;
        end
    end

    // State register; reset drops any pending hold or flush immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pipeline data: flush inserts a NOP bubble with PC 0, hold keeps everything,
    // an invalid fetch inserts a bubble but leaves the PC where it was.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_o    <= '0;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (take_flush) begin
            pc_o    <= '0;
            instr_o <= NOP_INSTR;
            valid_o <= 1'b0;
        end else if (!take_hold) begin
            if (valid_i) begin
                pc_o    <= pc_i;
                instr_o <= instr_i;
                valid_o <= 1'b1;
            end else begin
                instr_o <= NOP_INSTR;
                valid_o <= 1'b0;
            end
        end
    end

    // Consecutive hold counter (saturating) and the sticky watchdog it feeds; the
    // watchdog fires when a hold continues past HOLD_MAX consecutive hold edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            watchdog_o <= 1'b0;
        end else if (take_hold) begin
            if (hold_cnt_q != 8'hFF) begin
                hold_cnt_q <= hold_cnt_q + 8'd1;
            end
            if (hold_cnt_q == HOLD_MAX_C) begin
                watchdog_o <= 1'b1;
            end
        end else begin
            hold_cnt_q <= '0;
        end
    end

    assign holding_o = (state_q == HOLD);

    // Register-address fields are plain slices of the registered instruction.
    generate
        if (REG_ADDR_W == 5) begin : g_addr_exact
            assign rs1_addr_o = instr_o[19:15];
            assign rs2_addr_o = instr_o[24:20];
            assign rd_addr_o  = instr_o[11:7];
        end else if (REG_ADDR_W > 5) begin : g_addr_wide
            assign rs1_addr_o = {{(REG_ADDR_W-5){1'b0}}, instr_o[19:15]};
            assign rs2_addr_o = {{(REG_ADDR_W-5){1'b0}}, instr_o[24:20]};
            assign rd_addr_o  = {{(REG_ADDR_W-5){1'b0}}, instr_o[11:7]};
        end else begin : g_addr_narrow
            assign rs1_addr_o = instr_o[15 +: REG_ADDR_W];
            assign rs2_addr_o = instr_o[20 +: REG_ADDR_W];
            assign rd_addr_o  = instr_o[7 +: REG_ADDR_W];
        end
    endgenerate

`ifdef IF_ID_STALL_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Lifetime totals of hold and flush edges; they wrap and only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (take_hold) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (take_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed scenarios plus a randomized run, each checked
// against a transaction-level reference model of the IF/ID register.

module tb_if_id_stage;

    localparam int          XLEN     = 32;
    localparam int          RW       = 5;
    localparam int          HOLD_MAX = 4;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [XLEN-1:0] pc_i = '0;
    logic [XLEN-1:0] instr_i = '0;
    logic            valid_i = 1'b0;
    logic            IF_ID_write_i = 1'b1;
    logic            flush_i = 1'b0;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] instr_o;
    logic            valid_o;
    logic [RW-1:0]   rs1_addr_o;
    logic [RW-1:0]   rs2_addr_o;
    logic [RW-1:0]   rd_addr_o;
    logic            holding_o;
    logic            watchdog_o;
    logic [31:0]     stall_cnt_o;
    logic [31:0]     flush_cnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model state: what the stage should hold after each edge.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_holding;
    logic        m_wd;
    int          m_run;
    logic [31:0] m_stalls;
    logic [31:0] m_flushes;

    if_id_stage #(
        .XLEN(XLEN),
        .REG_ADDR_W(RW),
        .NOP_INSTR(NOP),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .pc_i(pc_i),
        .instr_i(instr_i),
        .valid_i(valid_i),
        .IF_ID_write_i(IF_ID_write_i),
        .flush_i(flush_i),
        .pc_o(pc_o),
        .instr_o(instr_o),
        .valid_o(valid_o),
        .rs1_addr_o(rs1_addr_o),
        .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o),
        .holding_o(holding_o),
        .watchdog_o(watchdog_o),
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] exp_stalls();
`ifdef IF_ID_STALL_STATS_EN
        return m_stalls;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_flushes();
`ifdef IF_ID_STALL_STATS_EN
        return m_flushes;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_pc      = '0;
        m_instr   = NOP;
        m_valid   = 1'b0;
        m_holding = 1'b0;
        m_wd      = 1'b0;
        m_run     = 0;
        m_stalls  = '0;
        m_flushes = '0;
    endtask

    // One edge of the stage in spec terms: flush, else hold, else load/bubble.
    task automatic model_edge(input logic [31:0] pc, input logic [31:0] instr,
                              input logic v, input logic wr, input logic fl);
        if (fl) begin
            m_pc = '0; m_instr = NOP; m_valid = 1'b0;
            m_holding = 1'b0; m_run = 0; m_flushes = m_flushes + 1;
        end else if (!wr) begin
            m_holding = 1'b1;
            m_run = m_run + 1;
            if (m_run > HOLD_MAX) m_wd = 1'b1;
            m_stalls = m_stalls + 1;
        end else begin
            m_holding = 1'b0;
            m_run = 0;
            if (v) begin
                m_pc = pc; m_instr = instr; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample 1ns after the rising edge.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic v, input logic wr, input logic fl);
        @(negedge clk_i);
        pc_i = pc; instr_i = instr; valid_i = v; IF_ID_write_i = wr; flush_i = fl;
        model_edge(pc, instr, v, wr, fl);
        @(posedge clk_i);
        #1;
    endtask

    task automatic sync_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        model_reset();
        #2;
        checks++;
        if (pc_o !== 32'd0 || instr_o !== NOP || valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data: pc=%h instr=%h valid=%b, required pc=0 instr=%h valid=0", pc_o, instr_o, valid_o, NOP);
        end
        checks++;
        if (rs1_addr_o !== 5'd0 || rs2_addr_o !== 5'd0 || rd_addr_o !== 5'd0 || holding_o !== 1'b0 || watchdog_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: rs1=%0d rs2=%0d rd=%0d hold=%b wd=%b, required all 0", rs1_addr_o, rs2_addr_o, rd_addr_o, holding_o, watchdog_o);
        end
        checks++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts: stall=%0d flush=%0d, required 0/0", stall_cnt_o, flush_cnt_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_load();
        applyStimulus(32'h100, 32'h00A30293, 1'b1, 1'b1, 1'b0);
        checks++;
        if (pc_o !== 32'h100 || instr_o !== 32'h00A30293 || valid_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_data: pc=%h instr=%h valid=%b, required 100/00a30293/1", pc_o, instr_o, valid_o);
        end
        checks++;
        if (rs1_addr_o !== 5'd6 || rd_addr_o !== 5'd5 || rs2_addr_o !== 5'd10 || holding_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_fields: rs1=%0d rs2=%0d rd=%0d hold=%b, required 6/10/5/0", rs1_addr_o, rs2_addr_o, rd_addr_o, holding_o);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h104, 32'h00B38313, 1'b1, 1'b0, 1'b0);
            checks++;
            if (pc_o !== 32'h100 || instr_o !== 32'h00A30293 || valid_o !== 1'b1 || holding_o !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_%0d: pc=%h instr=%h valid=%b hold=%b, required 100/00a30293/1/1", i, pc_o, instr_o, valid_o, holding_o);
            end
        end
        checks++;
        if (stall_cnt_o !== exp_stalls()) begin
            failures++;
            $display("[TB] FAIL hold_stall_cnt: got %0d, required %0d", stall_cnt_o, exp_stalls());
        end
    endtask

    task automatic test_flush_during_hold();
        applyStimulus(32'h108, 32'h00C40393, 1'b1, 1'b0, 1'b1);
        checks++;
        if (instr_o !== NOP || valid_o !== 1'b0 || holding_o !== 1'b0 || pc_o !== 32'd0) begin
            failures++;
            $display("[TB] FAIL flush_in_hold: pc=%h instr=%h valid=%b hold=%b, required 0/%h/0/0", pc_o, instr_o, valid_o, holding_o, NOP);
        end
        checks++;
        if (flush_cnt_o !== exp_flushes()) begin
            failures++;
            $display("[TB] FAIL flush_cnt: got %0d, required %0d", flush_cnt_o, exp_flushes());
        end
        // Hold right after a flush must keep the bubble.
        applyStimulus(32'h10C, 32'h00D48413, 1'b1, 1'b0, 1'b0);
        checks++;
        if (instr_o !== NOP || valid_o !== 1'b0 || holding_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_after_flush: instr=%h valid=%b hold=%b, required %h/0/1", instr_o, valid_o, holding_o, NOP);
        end
    endtask

    task automatic test_bubble();
        applyStimulus(32'h200, 32'h00208033, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h204, 32'h00310133, 1'b0, 1'b1, 1'b0);
        checks++;
        if (instr_o !== NOP || valid_o !== 1'b0 || pc_o !== 32'h200 || holding_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bubble: pc=%h instr=%h valid=%b hold=%b, required 200/%h/0/0", pc_o, instr_o, valid_o, holding_o, NOP);
        end
    endtask

    task automatic test_watchdog();
        sync_reset();
        applyStimulus(32'h300, 32'h00A30293, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(32'h304, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (watchdog_o !== (i >= HOLD_MAX + 1)) begin
                failures++;
                $display("[TB] FAIL watchdog_hold_%0d: got %b, required %b", i, watchdog_o, (i >= HOLD_MAX + 1));
            end
        end
        applyStimulus(32'h304, 32'h00B38313, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h308, 32'h0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (watchdog_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL watchdog_sticky: got %b, required 1", watchdog_o);
        end
        sync_reset();
        #1;
        checks++;
        if (watchdog_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL watchdog_reset: got %b, required 0", watchdog_o);
        end
    endtask

    task automatic test_async_reset();
        applyStimulus(32'h400, 32'h00A30293, 1'b1, 1'b1, 1'b0);
        applyStimulus(32'h404, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(32'h404, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        checks++;
        if (pc_o !== 32'd0 || instr_o !== NOP || valid_o !== 1'b0 || holding_o !== 1'b0 || stall_cnt_o !== 32'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: pc=%h instr=%h valid=%b hold=%b stall=%0d, required 0/%h/0/0/0", pc_o, instr_o, valid_o, holding_o, stall_cnt_o, NOP);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] pc;
        logic [31:0] instr;
        logic        v;
        logic        wr;
        logic        fl;
        for (int n = 0; n < 400; n++) begin
            pc    = $urandom & 32'hFFFF_FFFC;
            instr = $urandom;
            v     = ($urandom_range(0, 3) != 0);
            wr    = ($urandom_range(0, 9) >= 4) || (n % 50 < 8 && n > 100 ? 1'b0 : 1'b0);
            if (n >= 200 && n < 210) wr = 1'b0;
            fl    = ($urandom_range(0, 9) == 0) && !(n >= 200 && n < 210);
            applyStimulus(pc, instr, v, wr, fl);
            checks++;
            if (pc_o !== m_pc || instr_o !== m_instr || valid_o !== m_valid) begin
                failures++;
                $display("[TB] FAIL rand_data_%0d: pc=%h instr=%h valid=%b, required %h/%h/%b", n, pc_o, instr_o, valid_o, m_pc, m_instr, m_valid);
            end
            checks++;
            if (rs1_addr_o !== m_instr[19:15] || rs2_addr_o !== m_instr[24:20] || rd_addr_o !== m_instr[11:7]) begin
                failures++;
                $display("[TB] FAIL rand_fields_%0d: rs1=%0d rs2=%0d rd=%0d, required %0d/%0d/%0d", n, rs1_addr_o, rs2_addr_o, rd_addr_o, m_instr[19:15], m_instr[24:20], m_instr[11:7]);
            end
            checks++;
            if (holding_o !== m_holding || watchdog_o !== m_wd || stall_cnt_o !== exp_stalls() || flush_cnt_o !== exp_flushes()) begin
                failures++;
                $display("[TB] FAIL rand_ctrl_%0d: hold=%b wd=%b stall=%0d flush=%0d, required %b/%b/%0d/%0d", n, holding_o, watchdog_o, stall_cnt_o, flush_cnt_o, m_holding, m_wd, exp_stalls(), exp_flushes());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_hold();
        test_flush_during_hold();
        test_bubble();
        test_watchdog();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
IF/ID pipeline register that receives the load-use hazard controls (IF_ID write-enable and the branch flush) and holds, flushes or loads the fetched instruction accordingly. It registers the PC and instruction together with the decoded rs1/rs2/rd fields, which the hazard unit compares next cycle. A consecutive-stall counter drives a sticky watchdog flag that catches a stall that never clears.

Parameters:
XLEN, 32, width of pc and instruction
REG_ADDR_W, 5, register-address field width on rs1/rs2/rd outputs
NOP_INSTR, 32'h00000013, instruction word inserted on flush or bubble (addi x0,x0,0)
HOLD_MAX, 16, consecutive hold cycles that set watchdog_o (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
pc_i  in  XLEN  PC of fetched instruction
instr_i  in  XLEN  fetched instruction word
valid_i  in  1  fetch output valid this cycle
IF_ID_write_i  in  1  1 = load stage, 0 = hold (from hazard unit)
flush_i  in  1  branch taken in ID; discard stage contents
pc_o  out  XLEN  registered PC
instr_o  out  XLEN  registered instruction
valid_o  out  1  registered instruction is real (not bubble)
rs1_addr_o  out  REG_ADDR_W  instr_o[19:15], zero-extended/truncated to REG_ADDR_W
rs2_addr_o  out  REG_ADDR_W  instr_o[24:20]
rd_addr_o  out  REG_ADDR_W  instr_o[11:7]
holding_o  out  1  1 while state is HOLD
watchdog_o  out  1  sticky: consecutive hold count reached HOLD_MAX
stall_cnt_o  out  32  total hold cycles (optional feature)
flush_cnt_o  out  32  total flush events (optional feature)

Behaviour:
- Reset (async, rst_i=1): pc_o=0, instr_o=NOP_INSTR, valid_o=0, rs/rd fields decoded from NOP_INSTR (rs1=0, rs2=0, rd=0), state=RUN, hold counter=0, watchdog_o=0, stall_cnt_o=0, flush_cnt_o=0. Reset mid-hold or mid-flush abandons all state immediately.
- Per-edge priority: flush_i > hold (IF_ID_write_i=0) > load.
- Flush: pc_o=0, instr_o=NOP_INSTR, valid_o=0, state->FLUSHED, hold counter cleared. A flush arriving while holding wins and ends the hold.
- Hold: all data outputs keep their values; state->HOLD; hold counter increments, saturating at 255. Entering HOLD from a flushed bubble keeps the bubble.
- Load with valid_i=1: pc_o=pc_i, instr_o=instr_i, valid_o=1, state->RUN, hold counter cleared.
- Load with valid_i=0: bubble (instr_o=NOP_INSTR, valid_o=0, pc_o keeps its value), state->RUN, hold counter cleared.
- States: RUN, HOLD, FLUSHED. Transitions follow the rules above. holding_o=(state==HOLD).
- Latency: one cycle from inputs to registered outputs. rs/rd outputs are combinational slices of instr_o, so they are valid in the same cycle as instr_o.
- Watchdog: when the hold counter equals HOLD_MAX at an edge where hold continues, watchdog_o is set on that edge. It stays 1 until reset; flush and load do not clear it.

Optional Feature:
IF_ID_STALL_STATS_EN
- Defined: stall_cnt_o increments on every edge taken as hold; flush_cnt_o increments on every edge taken as flush. Both are 32-bit, wrap from 0xFFFFFFFF to 0, and are cleared only by reset.
- Undefined: counter registers are not built; stall_cnt_o and flush_cnt_o are tied to 0. Ports remain present.

Test Plan:
- Reset, then load pc_i=0x100, instr_i=0x00A30293 (addi x5,x6,10), valid_i=1 -> next cycle pc_o=0x100, valid_o=1, rs1=6, rd=5, holding_o=0.
- IF_ID_write_i=0 for 3 cycles while pc_i changes to 0x104 -> outputs stay at 0x100/0x00A30293; holding_o=1; with STALL_STATS_EN, stall_cnt_o=3.
- Hold active and flush_i=1 on the same edge -> instr_o=0x00000013, valid_o=0, holding_o=0; with STALL_STATS_EN, flush_cnt_o=1.
- valid_i=0, IF_ID_write_i=1 -> instr_o=NOP_INSTR, valid_o=0, pc_o unchanged.
- HOLD_MAX=4, hold held for 6 cycles -> watchdog_o rises after the 5th hold edge; stays 1 after loads resume; clears only on rst_i.
- Assert rst_i asynchronously mid-hold between clock edges -> all outputs return to reset values immediately, without waiting for a clock edge.
